// File: rtl/gpio_periph.sv
// GPIO peripheral: byte-wide register file over buttons, switches, LEDs and
// 7-segment digit nibbles, with debounced buttons, sticky button events and
// a masked level interrupt.
module gpio_periph #(
  parameter int ADDR_W    = 9,
  parameter int N_BTN     = 4,
  parameter int N_SW      = 16,
  parameter int N_LED     = 16,
  parameter int N_DIG     = 4,
  parameter int DB_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rw_select,
  input  logic [ADDR_W-1:0]    address,
  input  logic [7:0]           data_in,
  output logic [7:0]           data_out,
  input  logic [N_BTN-1:0]     buttons,
  input  logic [N_SW-1:0]      switches,
  output logic [N_LED-1:0]     leds,
  output logic [4*N_DIG-1:0]   digits,
  output logic                 irq
);

  localparam int               CNT_W   = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  localparam logic [3:0] OFF_BTN_STATE = 4'd0;
  localparam logic [3:0] OFF_BTN_EVENT = 4'd1;
  localparam logic [3:0] OFF_SW_LO     = 4'd2;
  localparam logic [3:0] OFF_SW_HI     = 4'd3;
  localparam logic [3:0] OFF_LED_LO    = 4'd4;
  localparam logic [3:0] OFF_LED_HI    = 4'd5;
  localparam logic [3:0] OFF_IRQ_MASK  = 4'd6;

  logic             sel;
  logic [3:0]       off;
  logic             wr;

  logic [N_BTN-1:0] btn_p0, btn_p1;
  logic [N_SW-1:0]  sw_p0, sw_p1;

  logic [N_BTN-1:0] btn_state, btn_event, irq_mask;
  logic [N_BTN-1:0] state_nxt, event_nxt, rise, clr;
  logic [CNT_W-1:0] db_cnt  [N_BTN];
  logic [CNT_W-1:0] cnt_nxt [N_BTN];

  logic [N_LED-1:0]   led_q, led_nxt;
  logic [15:0]        led_pad;
  logic [4*N_DIG-1:0] digits_q;
  logic [7:0]         rdata;

  assign sel = &address[ADDR_W-1:4];
  assign off = address[3:0];
  assign wr  = rw_select & sel;

  assign leds   = led_q;
  assign digits = digits_q;

  // Two-flop synchronizers for the asynchronous button and switch inputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_p0 <= '0;
      btn_p1 <= '0;
      sw_p0  <= '0;
      sw_p1  <= '0;
    end else begin
      btn_p0 <= buttons;
      btn_p1 <= btn_p0;
      sw_p0  <= switches;
      sw_p1  <= sw_p0;
    end
  end

  // Debounce: count consecutive cycles where the synced input disagrees with the state
  always_comb begin
    state_nxt = btn_state;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_nxt[i] = '0;
      if (btn_p1[i] != btn_state[i]) begin
        if (db_cnt[i] == CNT_MAX) state_nxt[i] = ~btn_state[i];
        else                      cnt_nxt[i]   = db_cnt[i] + CNT_W'(1);
      end
    end
  end

  // Event bits: rising edges set, W1C clears; a coincident set beats the clear
  always_comb begin
    rise      = state_nxt & ~btn_state;
    clr       = (wr && off == OFF_BTN_EVENT) ? data_in[N_BTN-1:0] : '0;
    event_nxt = (btn_event & ~clr) | rise;
  end

  // Button state, debounce counters and sticky events
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_state <= '0;
      btn_event <= '0;
      for (int i = 0; i < N_BTN; i++) db_cnt[i] <= '0;
    end else begin
      btn_state <= state_nxt;
      btn_event <= event_nxt;
      for (int i = 0; i < N_BTN; i++) db_cnt[i] <= cnt_nxt[i];
    end
  end

  // LED byte-lane merge for the write path
  always_comb begin
    led_pad = 16'(led_q);
    if (wr && off == OFF_LED_LO) led_pad[7:0]  = data_in;
    if (wr && off == OFF_LED_HI) led_pad[15:8] = data_in;
    led_nxt = led_pad[N_LED-1:0];
  end

  // Writable registers: LEDs, interrupt mask, digit nibbles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q    <= '0;
      irq_mask <= '0;
      digits_q <= '0;
    end else begin
      led_q <= led_nxt;
      if (wr && off == OFF_IRQ_MASK) irq_mask <= data_in[N_BTN-1:0];
      for (int i = 0; i < N_DIG; i++) begin
        if (wr && off == 4'(8 + i)) digits_q[4*i +: 4] <= data_in[3:0];
      end
    end
  end

  // Read mux: anything unselected or unmapped reads as zero
  always_comb begin
    rdata = '0;
    if (sel) begin
      case (off)
        OFF_BTN_STATE: rdata = 8'(btn_state);
        OFF_BTN_EVENT: rdata = 8'(btn_event);
        OFF_SW_LO:     rdata = 8'(16'(sw_p1));
        OFF_SW_HI:     rdata = 8'(16'(sw_p1) >> 8);
        OFF_LED_LO:    rdata = 8'(16'(led_q));
        OFF_LED_HI:    rdata = 8'(16'(led_q) >> 8);
        OFF_IRQ_MASK:  rdata = 8'(irq_mask);
        default: begin
          for (int i = 0; i < N_DIG; i++) begin
            if (off == 4'(8 + i)) rdata = {4'b0000, digits_q[4*i +: 4]};
          end
        end
      endcase
    end
  end

  // Registered read data (held during writes) and level interrupt
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out <= '0;
      irq      <= 1'b0;
    end else begin
      if (!rw_select) data_out <= rdata;
      irq <= |(btn_event & irq_mask);
    end
  end

endmodule

// File: tb/tb_gpio_periph.sv
// Testbench for gpio_periph: register-map vector table plus hand-written
// sequences for debounce, events, W1C collision, interrupt and reset.
module tb_gpio_periph;

  logic        clk;
  logic        reset;
  logic        rw_select;
  logic [8:0]  address;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic [3:0]  buttons;
  logic [15:0] switches;
  logic [15:0] leds;
  logic [15:0] digits;
  logic        irq;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  string      name_q[$];

  typedef struct packed {
    logic        rw;
    logic [8:0]  addr;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic [15:0] leds;
    logic [15:0] digits;
  } vec_t;

  vec_t vecs[$];

  gpio_periph #(
    .ADDR_W(9), .N_BTN(4), .N_SW(16), .N_LED(16), .N_DIG(4), .DB_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .rw_select(rw_select), .address(address),
    .data_in(data_in), .data_out(data_out), .buttons(buttons),
    .switches(switches), .leds(leds), .digits(digits), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic [8:0] a, input logic [7:0] d);
    rw_select = rw;
    address   = a;
    data_in   = d;
  endtask

  task automatic expect_rd(input logic [7:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic tick();
    logic [7:0] e;
    string      nm;
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      check(nm, 32'(data_out), 32'(e));
    end
  endtask

  initial begin
    vec_t v;

    // rw, addr, din, expected data_out, expected leds, expected digits
    vecs.push_back('{1'b1, 9'h1F4, 8'hA5, 8'h00, 16'h00A5, 16'h0000});
    vecs.push_back('{1'b1, 9'h1F5, 8'h3C, 8'h00, 16'h3CA5, 16'h0000});
    vecs.push_back('{1'b0, 9'h1F5, 8'h00, 8'h3C, 16'h3CA5, 16'h0000});
    vecs.push_back('{1'b0, 9'h1F4, 8'h00, 8'hA5, 16'h3CA5, 16'h0000});
    vecs.push_back('{1'b1, 9'h1F9, 8'hF7, 8'hA5, 16'h3CA5, 16'h0070});
    vecs.push_back('{1'b0, 9'h1F9, 8'h00, 8'h07, 16'h3CA5, 16'h0070});
    vecs.push_back('{1'b0, 9'h1FF, 8'h00, 8'h00, 16'h3CA5, 16'h0070});
    vecs.push_back('{1'b0, 9'h000, 8'h00, 8'h00, 16'h3CA5, 16'h0070});
    vecs.push_back('{1'b0, 9'h1F2, 8'h00, 8'hEF, 16'h3CA5, 16'h0070});
    vecs.push_back('{1'b0, 9'h1F3, 8'h00, 8'hBE, 16'h3CA5, 16'h0070});
    vecs.push_back('{1'b1, 9'h0F4, 8'hFF, 8'hBE, 16'h3CA5, 16'h0070});
    vecs.push_back('{1'b1, 9'h1F2, 8'h00, 8'hBE, 16'h3CA5, 16'h0070});
    vecs.push_back('{1'b0, 9'h1F2, 8'h00, 8'hEF, 16'h3CA5, 16'h0070});
    vecs.push_back('{1'b0, 9'h1F6, 8'h00, 8'h00, 16'h3CA5, 16'h0070});
    vecs.push_back('{1'b1, 9'h1F6, 8'hFF, 8'h00, 16'h3CA5, 16'h0070});
    vecs.push_back('{1'b0, 9'h1F6, 8'h00, 8'h0F, 16'h3CA5, 16'h0070});
    vecs.push_back('{1'b0, 9'h1F7, 8'h00, 8'h00, 16'h3CA5, 16'h0070});
    vecs.push_back('{1'b1, 9'h1F8, 8'h5A, 8'h00, 16'h3CA5, 16'h007A});
    vecs.push_back('{1'b0, 9'h1F8, 8'h00, 8'h0A, 16'h3CA5, 16'h007A});
    vecs.push_back('{1'b1, 9'h1FC, 8'hFF, 8'h0A, 16'h3CA5, 16'h007A});
    vecs.push_back('{1'b0, 9'h1FC, 8'h00, 8'h00, 16'h3CA5, 16'h007A});
    vecs.push_back('{1'b0, 9'h1F0, 8'h00, 8'h00, 16'h3CA5, 16'h007A});
    vecs.push_back('{1'b0, 9'h1F1, 8'h00, 8'h00, 16'h3CA5, 16'h007A});
    vecs.push_back('{1'b1, 9'h1F6, 8'h04, 8'h00, 16'h3CA5, 16'h007A});
    vecs.push_back('{1'b0, 9'h1F6, 8'h00, 8'h04, 16'h3CA5, 16'h007A});

    reset     = 1'b0;
    rw_select = 1'b0;
    address   = '0;
    data_in   = '0;
    buttons   = '0;
    switches  = 16'hBEEF;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst data_out", 32'(data_out), 32'h0);
    check("rst leds",     32'(leds),     32'h0);
    check("rst digits",   32'(digits),   32'h0);
    check("rst irq",      32'(irq),      32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) tick();

    // Register map table
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v.rw, v.addr, v.din);
      expect_rd(v.dout, $sformatf("vec%0d data_out", i));
      tick();
      check($sformatf("vec%0d leds", i),   32'(leds),   32'(v.leds));
      check($sformatf("vec%0d digits", i), 32'(digits), 32'(v.digits));
    end

    // Short glitch on button 0 must not register
    drive(1'b0, 9'h000, 8'h00);
    buttons = 4'b0001;
    repeat (10) tick();
    buttons = 4'b0000;
    repeat (25) tick();
    drive(1'b0, 9'h1F0, 8'h00);
    expect_rd(8'h00, "glitch btn_state");
    tick();
    drive(1'b0, 9'h1F1, 8'h00);
    expect_rd(8'h00, "glitch btn_event");
    tick();
    check("glitch irq", 32'(irq), 32'h0);

    // Button 2 held 40 clocks: state flips after 2 sync + 16 clocks, irq one later
    drive(1'b0, 9'h1F0, 8'h00);
    buttons = 4'b0100;
    for (int i = 1; i <= 19; i++) begin
      expect_rd((i >= 19) ? 8'h04 : 8'h00, $sformatf("press btn_state t%0d", i));
      tick();
      check($sformatf("press irq t%0d", i), 32'(irq), (i >= 19) ? 32'd1 : 32'd0);
    end
    drive(1'b0, 9'h1F1, 8'h00);
    repeat (20) tick();
    expect_rd(8'h04, "press btn_event");
    tick();
    buttons = 4'b0000;
    repeat (25) tick();
    drive(1'b0, 9'h1F0, 8'h00);
    expect_rd(8'h00, "release btn_state");
    tick();
    drive(1'b0, 9'h1F1, 8'h00);
    expect_rd(8'h04, "release btn_event sticky");
    tick();
    check("release irq", 32'(irq), 32'h1);

    // W1C landing on the same edge as a new rising event: set wins
    drive(1'b0, 9'h000, 8'h00);
    buttons = 4'b0100;
    repeat (17) tick();
    drive(1'b1, 9'h1F1, 8'h04);
    tick();
    drive(1'b0, 9'h1F1, 8'h00);
    expect_rd(8'h04, "collide btn_event");
    tick();
    check("collide irq", 32'(irq), 32'h1);
    drive(1'b1, 9'h1F1, 8'h00);
    tick();
    drive(1'b0, 9'h1F1, 8'h00);
    expect_rd(8'h04, "w1c zero btn_event");
    tick();
    drive(1'b1, 9'h1F1, 8'h04);
    tick();
    check("w1c irq lag", 32'(irq), 32'h1);
    drive(1'b0, 9'h1F1, 8'h00);
    expect_rd(8'h00, "w1c btn_event");
    tick();
    check("w1c irq drop", 32'(irq), 32'h0);

    // Asynchronous reset mid-cycle with LEDs lit and button 1 mid-debounce
    drive(1'b1, 9'h1F4, 8'hFF);
    tick();
    drive(1'b1, 9'h1F5, 8'hFF);
    tick();
    check("leds all on", 32'(leds), 32'hFFFF);
    buttons = 4'b0110;
    drive(1'b0, 9'h1F1, 8'h00);
    repeat (8) tick();
    #2;
    reset = 1'b0;
    #1;
    check("async rst leds",     32'(leds),     32'h0);
    check("async rst digits",   32'(digits),   32'h0);
    check("async rst irq",      32'(irq),      32'h0);
    check("async rst data_out", 32'(data_out), 32'h0);
    #1;
    reset = 1'b1;

    // Buttons held across reset release need a full window before an event
    for (int i = 1; i <= 19; i++) begin
      expect_rd((i >= 19) ? 8'h06 : 8'h00, $sformatf("post-rst btn_event t%0d", i));
      tick();
    end
    check("post-rst irq masked", 32'(irq), 32'h0);
    drive(1'b0, 9'h1F6, 8'h00);
    expect_rd(8'h00, "post-rst irq_mask");
    tick();
    drive(1'b0, 9'h1F4, 8'h00);
    expect_rd(8'h00, "post-rst led_lo");
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_periph.md
GPIO_PERIPH -- requirements
Module: gpio_periph

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 9, meaning the byte-address width.
REQ-002 The block SHALL have parameter N_BTN, default 4 (1..8), meaning the button count.
REQ-003 The block SHALL have parameter N_SW, default 16 (1..16), meaning the switch count.
REQ-004 The block SHALL have parameter N_LED, default 16 (1..16), meaning the LED count.
REQ-005 The block SHALL have parameter N_DIG, default 4 (1..8), meaning the 7-seg digit-nibble count.
REQ-006 The block SHALL have parameter DB_CYCLES, default 16 (>=2), meaning the button debounce stability window in clocks.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock, rising edge only.
REQ-008 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-009 The block SHALL have port rw_select, input, 1 bit: 1 = write, 0 = read, sampled every cycle.
REQ-010 The block SHALL have port address, input, ADDR_W bits: the byte address.
REQ-011 The block SHALL have ports data_in (input) and data_out (output), 8 bits each: write data and registered read data.
REQ-012 The block SHALL have port buttons, input, N_BTN bits: asynchronous, active-high.
REQ-013 The block SHALL have port switches, input, N_SW bits: asynchronous.
REQ-014 The block SHALL have port leds, output, N_LED bits: registered.
REQ-015 The block SHALL have port digits, output, 4*N_DIG bits: registered; nibble i is digit i.
REQ-016 The block SHALL have port irq, output, 1 bit: registered, level, active-high.

Function
REQ-017 The block SHALL decode as selected when address[ADDR_W-1:4] is all ones; offset = address[3:0].
REQ-018 The register map SHALL be: 0 BTN_STATE RO; 1 BTN_EVENT W1C; 2 SW_LO RO; 3 SW_HI RO; 4 LED_LO RW; 5 LED_HI RW; 6 IRQ_MASK RW; 8..8+N_DIG-1 DIGIT[i] RW, bits[3:0] only.
REQ-019 Unimplemented bits, unmapped offsets and unselected addresses SHALL read 0; writes to them, and to RO registers, SHALL be ignored.
REQ-020 A write SHALL update the target register at the rising edge where rw_select=1; the result SHALL be visible on leds/digits the same edge.
REQ-021 A read (rw_select=0) SHALL present register contents on data_out after the next rising edge (1-cycle latency); data_out SHALL hold its value during writes.
REQ-022 A read in the cycle immediately after a write to the same register SHALL return the new value.
REQ-023 Buttons and switches SHALL each pass through a 2-flop synchronizer; SW_LO/SW_HI SHALL return the synchronized switches without debounce.
REQ-024 Each button SHALL have a counter: it clears when synced == BTN_STATE bit, otherwise increments; on reaching DB_CYCLES-1 the BTN_STATE bit toggles and the counter clears.
REQ-025 Glitches shorter than DB_CYCLES clocks SHALL never change BTN_STATE.
REQ-026 A 0->1 transition of a BTN_STATE bit SHALL set the matching BTN_EVENT bit (sticky); writing 1 to a BTN_EVENT bit SHALL clear it; writing 0 SHALL have no effect.
REQ-027 When a set and a W1C clear hit the same BTN_EVENT bit in the same cycle, the set SHALL win.
REQ-028 irq SHALL equal the registered OR of (BTN_EVENT & IRQ_MASK), 1 cycle after the event register changes.

Reset
REQ-029 While reset=0, all registers, synchronizers and debounce counters SHALL clear asynchronously: data_out=0, leds=0, digits=0, irq=0, IRQ_MASK=0, BTN_STATE=0, BTN_EVENT=0.
REQ-030 Reset deassertion SHALL take effect synchronously at the first rising edge with reset=1; reset mid-debounce SHALL discard partial counts.
REQ-031 Buttons already held at reset release SHALL generate an event only after a full debounce window.

Verification
REQ-032 Write 0xA5 to offset 4 and 0x3C to offset 5 -> leds=0x3CA5 on that edge; a read of offset 5 the next cycle returns data_out=0x3C.
REQ-033 Button 2 held high for 40 clocks (DB_CYCLES=16) -> BTN_STATE=0x04 after 2 sync + 16 clocks; BTN_EVENT=0x04; with IRQ_MASK=0x04, irq=1 one cycle later.
REQ-034 Button 0 pulsed high for 10 clocks -> BTN_STATE, BTN_EVENT and irq stay 0.
REQ-035 W1C of BTN_EVENT=0x04 in the same cycle as a new button-2 rising event -> bit stays 1; a later W1C with no event -> 0, irq drops 1 cycle later.
REQ-036 Write 0xF7 to offset 9 -> digits nibble 1 = 0x7; reading offset 9 -> 0x07; reading offset 0xF and address 0x000 -> 0x00.
REQ-037 Assert reset=0 asynchronously mid-cycle while leds=0xFFFF -> leds=0 immediately, before the next clock edge.
